// File: rtl/mem_rd_pkg.sv
// Shared definitions for the memory result reader: FSM state encoding and
// default widths of the cpu_top read port and checksum.
package mem_rd_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 4;
    localparam int SUM_W_DEF  = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector with asynchronous reset; a level already high when
// reset releases must drop low before it can produce an edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q   <= 1'b0;
            armed <= 1'b0;
        end else begin
            d_q <= d;
            if (!d)
                armed <= 1'b1;
        end
    end

    assign rise = d & ~d_q & armed;

endmodule

// File: rtl/mem_result_reader.sv
// Scans cpu_top data memory after its completion flag rises and streams each
// word out over a valid/ready handshake, accumulating a running checksum.
module mem_result_reader
    import mem_rd_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [SUM_W-1:0]  checksum,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    state_t          state;
    logic            start;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] idx_inc;
    logic [ADDR_W:0] last_idx;

    rise_detect u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (flag),
        .rise  (start)
    );

    assign idx_inc  = idx + ONE;
    assign last_idx = len_q - ONE;

    // rd_addr is loaded ahead of ADDR so the registered read returns the word in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            idx       <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            checksum  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        idx      <= '0;
                        rd_addr  <= '0;
                        checksum <= '0;
                        busy     <= 1'b1;
                        state    <= (len == '0) ? ST_FIN : ST_ADDR;
                    end
                end
                ST_ADDR: state <= ST_WAIT;
                ST_WAIT: begin
                    out_data  <= rd_data;
                    out_addr  <= idx[ADDR_W-1:0];
                    out_valid <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        checksum  <= checksum + SUM_W'(out_data);
                        idx       <= idx_inc;
                        if (idx == last_idx) begin
                            state <= ST_FIN;
                        end else begin
                            rd_addr <= idx_inc[ADDR_W-1:0];
                            state   <= ST_ADDR;
                        end
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_result_reader.sv
// Bench for mem_result_reader: a 32x4 memory with registered read stands in
// for cpu_top; a queue-free reference derives expected words and checksum.
module tb_mem_result_reader;

    logic       clk;
    logic       rst_n;
    logic       flag;
    logic [5:0] len;
    logic [4:0] rd_addr;
    logic [3:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [4:0] out_addr;
    logic [7:0] checksum;
    logic       busy;
    logic       done;

    logic [3:0] mem [32];

    int total = 0;
    int bad   = 0;

    mem_result_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flag      (flag),
        .len       (len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .checksum  (checksum),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete scan: start edge, optional re-pulse of flag at word reflag_at,
    // out_ready asserted with probability rdy_pct percent.
    task automatic run_scan(input int n, input int rdy_pct, input int reflag_at);
        int         k, cyc, first_v, max_addr;
        bit         ended, reflagged;
        logic       pv, pr;
        logic [3:0] pd;
        logic [4:0] pa;
        logic [7:0] exp_sum;
        exp_sum = 8'h00;
        for (int i = 0; i < n; i++) exp_sum = exp_sum + 8'(mem[i]);
        max_addr  = (n == 0) ? 0 : n - 1;
        k         = 0;
        cyc       = 0;
        first_v   = -1;
        ended     = 1'b0;
        reflagged = 1'b0;
        @(posedge clk); #1;
        flag = 1'b1;
        len  = 6'(n);
        while (!ended && cyc < 3000) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr;
            @(posedge clk); #1;
            cyc++;
            if (flag) flag = 1'b0;
            else if (reflag_at >= 0 && !reflagged && k == reflag_at) begin
                flag      = 1'b1;
                reflagged = 1'b1;
            end
            if (pv && pr) begin
                if (k >= n) chk("extra_word", k, n);
                else begin
                    chk("word_data", pd, mem[k]);
                    chk("word_addr", pa, k);
                end
                k++;
            end else if (pv) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, pd);
                chk("stall_addr", out_addr, pa);
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (busy && rd_addr > max_addr) chk("rd_addr_range", rd_addr, max_addr);
            if (done) begin
                ended = 1'b1;
                chk("busy_at_done", busy, 0);
                chk("word_count", k, n);
                chk("checksum", checksum, exp_sum);
                if (rdy_pct >= 100) chk("done_latency", cyc, (n == 0) ? 2 : 3 * n + 2);
            end
        end
        chk("scan_ended", ended, 1);
        if (n == 0) chk("no_valid_len0", first_v, -1);
        else if (rdy_pct >= 100) chk("first_valid_latency", first_v, 3);
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("checksum_held", checksum, exp_sum);
        chk("idle_no_valid", out_valid, 0);
    endtask

    initial begin
        int  cyc;
        bit  restarted;
        rst_n     = 1'b0;
        flag      = 1'b0;
        len       = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 4'(i);
        #3;
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_data", out_data, 0);
        chk("reset_addr", out_addr, 0);
        chk("reset_checksum", checksum, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // incrementing memory, full throughput then random back-pressure
        run_scan(24, 100, -1);
        run_scan(24, 30, -1);

        // all-ones memory, full depth, checksum wraps
        for (int i = 0; i < 32; i++) mem[i] = 4'hF;
        run_scan(32, 100, -1);
        chk("wrap_checksum", checksum, 8'hE0);

        // empty scan
        run_scan(0, 100, -1);

        // flag re-pulsed mid-scan, then a fresh scan clears the checksum
        for (int i = 0; i < 32; i++) mem[i] = 4'($urandom_range(15));
        run_scan(16, 70, 5);
        for (int i = 0; i < 32; i++) mem[i] = 4'($urandom_range(15));
        run_scan(10, 50, -1);

        // asynchronous reset at word 10 with flag held high across release
        @(posedge clk); #1;
        flag      = 1'b1;
        len       = 6'd20;
        out_ready = 1'b1;
        cyc       = 0;
        while (!(out_valid && out_addr == 5'd10) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_word10", cyc < 200, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rd_addr", rd_addr, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_data", out_data, 0);
        chk("abort_addr", out_addr, 0);
        chk("abort_checksum", checksum, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        restarted = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (busy || out_valid || done) restarted = 1'b1;
        end
        chk("no_restart_flag_high", restarted, 0);
        flag = 1'b0;
        run_scan(12, 100, -1);

        // random memory, lengths and back-pressure
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = 4'($urandom_range(15));
            run_scan($urandom_range(32, 1), $urandom_range(100, 20), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
